// File: rtl/board_drawer.sv
// board_drawer: full-board draw/clear sweep engine between the board RAM and the VGA adapter
module board_drawer #(
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120,
   parameter bit SKIP_EMPTY = 1'b0
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start_draw,
   input  logic        start_clear,
   output logic        busy,
   output logic        done,
   output logic [14:0] ram_address,
   output logic        ram_wren,
   output logic [2:0]  ram_data,
   input  logic [2:0]  ram_q,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot
);
   typedef enum logic [2:0] {IDLE, DRAW_RD, DRAW_WT, DRAW_PL, CLEAR, FINISH} state_t;
   localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
   localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);
   state_t      state, state_n;
   logic [7:0]  xc, xc_n, x_adv, x_n;
   logic [6:0]  yc, yc_n, y_adv, y_n;
   logic        last, busy_n, done_n, wren_n, plot_n;
   logic [14:0] addr_n;
   logic [2:0]  colour_n;
   assign last     = (xc == X_LAST) && (yc == Y_LAST);
   assign x_adv    = (xc == X_LAST) ? 8'd0 : xc + 8'd1;
   assign y_adv    = (xc == X_LAST) ? yc + 7'd1 : yc;
   assign ram_data = 3'b000;
   // next state, next counters and the registered output values for the next cycle
   always_comb begin
      state_n  = state;
      xc_n     = xc;
      yc_n     = yc;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      wren_n   = 1'b0;
      plot_n   = 1'b0;
      addr_n   = '0;
      x_n      = '0;
      y_n      = '0;
      colour_n = '0;
      case (state)
         IDLE: begin
            if (start_clear) begin
               state_n = CLEAR;
               busy_n  = 1'b1;
               wren_n  = 1'b1;
               plot_n  = 1'b1;
               addr_n  = {xc, yc};
               x_n     = xc;
               y_n     = yc;
            end else if (start_draw) begin
               state_n = DRAW_RD;
               busy_n  = 1'b1;
               addr_n  = {xc, yc};
            end
         end
         DRAW_RD: begin
            state_n = DRAW_WT;
            busy_n  = 1'b1;
            addr_n  = {xc, yc};
         end
         DRAW_WT: begin
            state_n  = DRAW_PL;
            busy_n   = 1'b1;
            addr_n   = {xc, yc};
            x_n      = xc;
            y_n      = yc;
            colour_n = ram_q;
            plot_n   = !(SKIP_EMPTY && ram_q == 3'b000);
         end
         DRAW_PL: begin
            if (last) begin
               state_n = FINISH;
               done_n  = 1'b1;
               xc_n    = '0;
               yc_n    = '0;
            end else begin
               state_n = DRAW_RD;
               busy_n  = 1'b1;
               xc_n    = x_adv;
               yc_n    = y_adv;
               addr_n  = {x_adv, y_adv};
            end
         end
         CLEAR: begin
            if (last) begin
               state_n = FINISH;
               done_n  = 1'b1;
               xc_n    = '0;
               yc_n    = '0;
            end else begin
               busy_n = 1'b1;
               wren_n = 1'b1;
               plot_n = 1'b1;
               xc_n   = x_adv;
               yc_n   = y_adv;
               addr_n = {x_adv, y_adv};
               x_n    = x_adv;
               y_n    = y_adv;
            end
         end
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state, counters and every output are registered together
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         xc          <= '0;
         yc          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_wren    <= 1'b0;
         plot        <= 1'b0;
         ram_address <= '0;
         x           <= '0;
         y           <= '0;
         colour      <= '0;
      end else begin
         state       <= state_n;
         xc          <= xc_n;
         yc          <= yc_n;
         busy        <= busy_n;
         done        <= done_n;
         ram_wren    <= wren_n;
         plot        <= plot_n;
         ram_address <= addr_n;
         x           <= x_n;
         y           <= y_n;
         colour      <= colour_n;
      end
   end
endmodule

// File: tb/tb_board_drawer.sv
// tb_board_drawer: directed checks of board_drawer clear, draw, skip-empty and reset behaviour
module tb_board_drawer;
   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1, start_draw = 1'b0, start_clear = 1'b0, start_draw1 = 1'b0;
   logic        clear1 = 1'b0;
   logic        busy, done, ram_wren, plot, busy1, done1, ram_wren1, plot1;
   logic [14:0] ram_address, ram_address1;
   logic [2:0]  ram_data, ram_data1, colour, colour1, ram_q, ram_q1;
   logic [7:0]  x, x1;
   logic [6:0]  y, y1;
   logic [2:0]  mem0 [32768];
   logic [2:0]  mem1 [32768];
   int          npass = 0, nfail = 0, ntotal = 0;
   logic [39:0] outs;
   assign outs = {busy, done, ram_address, ram_wren, ram_data, x, y, colour, plot};
   always #5 CLOCK_50 = ~CLOCK_50;
   board_drawer dut0 (
      .CLOCK_50(CLOCK_50), .reset(reset), .start_draw(start_draw), .start_clear(start_clear),
      .busy(busy), .done(done), .ram_address(ram_address), .ram_wren(ram_wren),
      .ram_data(ram_data), .ram_q(ram_q), .x(x), .y(y), .colour(colour), .plot(plot)
   );
   board_drawer #(.SKIP_EMPTY(1'b1)) dut1 (
      .CLOCK_50(CLOCK_50), .reset(reset), .start_draw(start_draw1), .start_clear(clear1),
      .busy(busy1), .done(done1), .ram_address(ram_address1), .ram_wren(ram_wren1),
      .ram_data(ram_data1), .ram_q(ram_q1), .x(x1), .y(y1), .colour(colour1), .plot(plot1)
   );
   always @(posedge CLOCK_50) begin
      if (ram_wren) mem0[ram_address] <= ram_data;
      if (ram_wren1) mem1[ram_address1] <= ram_data1;
      ram_q  <= mem0[ram_address];
      ram_q1 <= mem1[ram_address1];
   end
   function automatic logic [14:0] ca(input int cx, input int cy);
      return {8'(cx), 7'(cy)};
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ntotal++;
      assert (got === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask
   initial begin
      int dn, nz, bad, p0, p1, p1bad;
      for (int i = 0; i < 32768; i++) begin
         mem0[i] = 3'd7;
         mem1[i] = 3'd0;
      end
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      chk("reset_outs", 64'(outs), 64'd0);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("idle_outs", 64'(outs), 64'd0);
      end
      start_clear = 1'b1;
      start_draw  = 1'b1;
      tick;
      start_clear = 1'b0;
      start_draw  = 1'b0;
      dn = 0;
      for (int c = 1; c <= 19260; c++) begin
         if (c > 1) tick;
         if (done) dn++;
         if (c == 1) chk("clr_c1", {ram_wren, ram_address, plot, colour, busy}, {1'b1, 15'd0, 1'b1, 3'd0, 1'b1});
         if (c == 161) chk("clr_c161_xy", {x, y, ram_address}, {8'd0, 7'd1, ca(0, 1)});
         if (c == 5000) start_draw = 1'b1;
         if (c == 5001) start_draw = 1'b0;
         if (c == 19200) chk("clr_last", {x, y, plot, ram_wren, busy}, {8'd159, 7'd119, 3'b111});
         if (c == 19201) chk("clr_done", {done, busy, plot, ram_wren}, 4'b1000);
         if (c == 19260) chk("clr_no_extra", {busy, done}, 2'b00);
      end
      chk("clr_done_count", 64'(dn), 64'd1);
      nz = 0;
      for (int cx = 0; cx < 160; cx++)
         for (int cy = 0; cy < 120; cy++)
            if (mem0[ca(cx, cy)] !== 3'd0) nz++;
      chk("clr_mem_zero", 64'(nz), 64'd0);
      for (int i = 0; i < 32768; i++) begin
         mem0[i] = 3'd0;
         mem1[i] = 3'd0;
      end
      mem0[ca(0, 0)] = 3'd1;   mem1[ca(0, 0)] = 3'd1;
      mem0[ca(159, 0)] = 3'd2; mem1[ca(159, 0)] = 3'd2;
      mem0[ca(159, 119)] = 3'd6; mem1[ca(159, 119)] = 3'd6;
      start_draw  = 1'b1;
      start_draw1 = 1'b1;
      tick;
      start_draw  = 1'b0;
      start_draw1 = 1'b0;
      chk("drw_c1", {busy, ram_address, ram_wren, plot}, {1'b1, 15'd0, 1'b0, 1'b0});
      bad = 0; p0 = 0; p1 = 0; p1bad = 0;
      for (int c = 1; c <= 57602; c++) begin
         if (c > 1) tick;
         if (plot && (c % 3) != 0) bad++;
         if (plot) p0++;
         if (plot1) begin
            p1++;
            if (c != 3 && c != 480 && c != 57600) p1bad++;
         end
         if (c == 3) chk("drw_c3", {plot, x, y, colour}, {1'b1, 8'd0, 7'd0, 3'd1});
         if (c == 480) chk("drw_c480", {plot, x, y, colour}, {1'b1, 8'd159, 7'd0, 3'd2});
         if (c == 57600) chk("drw_last", {plot, x, y, colour}, {1'b1, 8'd159, 7'd119, 3'd6});
         if (c == 57601) chk("drw_done", {done, busy, done1}, 3'b101);
      end
      chk("drw_plot_phase", 64'(bad), 64'd0);
      chk("drw_plot_count", 64'(p0), 64'd19200);
      chk("skip_count", 64'(p1), 64'd3);
      chk("skip_cycles", 64'(p1bad), 64'd0);
      for (int i = 0; i < 32768; i++) mem0[i] = 3'd5;
      start_clear = 1'b1;
      tick;
      start_clear = 1'b0;
      repeat (99) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rst_outs", 64'(outs), 64'd0);
      dn = 0;
      repeat (20) begin
         tick;
         if (done) dn++;
      end
      chk("rst_no_done", 64'(dn), 64'd0);
      chk("rst_idle_outs", 64'(outs), 64'd0);
      nz = 0;
      for (int k = 0; k < 99; k++)
         if (mem0[ca(k, 0)] !== 3'd0) nz++;
      chk("rst_cleared_cells", 64'(nz), 64'd0);
      chk("rst_untouched", 64'(mem0[ca(20, 3)]), 64'd5);
      mem0[ca(0, 0)] = 3'd3;
      start_draw = 1'b1;
      tick;
      start_draw = 1'b0;
      chk("rst_redraw_addr", {busy, ram_address}, {1'b1, 15'd0});
      tick;
      tick;
      chk("rst_redraw_plot", {plot, x, y, colour}, {1'b1, 8'd0, 7'd0, 3'd3});
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
